// File: rtl/wave_ctrl_pkg.sv
// ============================================================================
// Module : wave_ctrl_pkg
// Purpose: Shared types and default sizes for the wave capture sequencer.
//          Defines the sequencer state encoding, the default stream/counter
//          widths and the default warm-up length.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wave_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 12;

  // Enabled datapath cycles thrown away after a filter clear: long enough to
  // flush the filter pipeline and fill all four of its taps.
  localparam int WARMUP_DEF = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    WARM  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } wave_state_e;

endpackage : wave_ctrl_pkg

`default_nettype wire

// File: rtl/wave_seq_counter.sv
// ============================================================================
// Module : wave_seq_counter
// Purpose: Up-counter with synchronous load-to-zero, increment enable and a
//          terminal-count flag that compares the current count against a
//          (possibly run-time) terminal value.
// Ports  : clk_i     clock
//          reset_ni  asynchronous active-low reset
//          clr_i     load zero (wins over inc_i)
//          inc_i     increment by one
//          term_i    terminal value
//          tc_o      high while count == term_i
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wave_seq_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule : wave_seq_counter

`default_nettype wire

// File: rtl/wave_capture_sequencer.sv
// ============================================================================
// Module : wave_capture_sequencer
// Purpose: Sequences the sine generator -> low-pass filter chain for one
//          capture burst: clear the filter, run a warm-up, then stream
//          burst_len filtered samples on a valid/ready port. The whole
//          datapath stalls on back-pressure so samples are never dropped or
//          duplicated.
// Ports  : clk_i, reset_ni           clock, async active-low reset
//          start_i, abort_i          burst request / cancel
//          burst_len_i, phase_step_i burst config, latched on accepted start
//          decim_i                   decimation factor-1 (DECIM_EN only)
//          gen_en_o, gen_step_o      generator enable and phase increment
//          filt_en_o, filt_clr_o     filter enable (== gen_en_o) and clear
//          filt_data_i               filtered sample
//          m_data_o, m_valid_o,
//          m_ready_i, m_last_o       output stream
//          busy_o, done_o, aborted_o status
// Config : `define DECIM_EN adds decim_i; only every (decim_i+1)-th filter
//          sample is presented, the datapath free-runs in between.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wave_capture_sequencer
  import wave_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  burst_len_i,
  input  logic [15:0]       phase_step_i,
`ifdef DECIM_EN
  input  logic [3:0]        decim_i,
`endif
  output logic              gen_en_o,
  output logic [15:0]       gen_step_o,
  output logic              filt_en_o,
  output logic              filt_clr_o,
  input  logic [DATA_W-1:0] filt_data_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o
);

  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WARM_W-1:0] WARM_TERM = WARM_W'(WARMUP - 1);

  wave_state_e      state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [15:0]      step_q, step_d;
  logic             aborted_q, aborted_d;

  logic accept;     // start taken in IDLE
  logic cancel;     // abort of an active burst
  logic handshake;
  logic warm_tc;
  logic burst_tc;   // current sample is the last of the burst
  logic present;    // current filter sample is offered on the stream

  assign accept    = (state_q == IDLE) && start_i && !abort_i;
  assign cancel    = (state_q != IDLE) && abort_i;
  assign handshake = m_valid_o && m_ready_i;

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  wave_seq_counter #(.W(WARM_W)) u_warm_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (state_q != WARM),
    .inc_i    (state_q == WARM),
    .term_i   (WARM_TERM),
    .tc_o     (warm_tc)
  );

  // Held at zero outside RUN, which also clears it on DONE and on abort.
  wave_seq_counter #(.W(CNT_W)) u_burst_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (state_q != RUN),
    .inc_i    (handshake),
    .term_i   (len_q - CNT_W'(1)),
    .tc_o     (burst_tc)
  );

`ifdef DECIM_EN
  // Counts free-running filter samples; the sample reached at count==decim
  // is presented and held until accepted, then counting restarts.
  wave_seq_counter #(.W(4)) u_decim_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    ((state_q != RUN) || handshake),
    .inc_i    ((state_q == RUN) && !present),
    .term_i   (decim_i),
    .tc_o     (present)
  );
`else
  assign present = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // State and configuration registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      len_q     <= '0;
      step_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      step_q    <= step_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    len_d     = len_q;
    step_d    = step_q;
    aborted_d = cancel;
    if (accept) begin
      len_d  = burst_len_i;
      step_d = phase_step_i;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (burst_len_i == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: state_d = WARM;
      WARM: begin
        if (warm_tc) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (handshake && burst_tc) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cancel) begin
      state_d = IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    gen_en_o   = 1'b0;
    filt_clr_o = 1'b0;
    m_valid_o  = 1'b0;
    done_o     = 1'b0;
    busy_o     = (state_q != IDLE);
    unique case (state_q)
      CLEAR: filt_clr_o = 1'b1;
      WARM:  gen_en_o   = 1'b1;
      RUN: begin
        if (present) begin
          // Advance only on acceptance so the offered sample stays put.
          m_valid_o = 1'b1;
          gen_en_o  = m_ready_i;
        end else begin
          gen_en_o  = 1'b1;
        end
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign filt_en_o  = gen_en_o;
  assign gen_step_o = step_q;
  assign m_data_o   = m_valid_o ? filt_data_i : '0;
  assign m_last_o   = m_valid_o && burst_tc;
  assign aborted_o  = aborted_q;

endmodule : wave_capture_sequencer

`default_nettype wire

// File: tb/tb_wave_capture_sequencer.sv
// ============================================================================
// Module : tb_wave_capture_sequencer
// Purpose: Directed, scoreboard-checked bench for wave_capture_sequencer.
//          The filter is stood in for by a counter that clears on filt_clr
//          and advances on filt_en, so the n-th sample after a clear has the
//          value 16'hA000 + n and every expected sample is known up front.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wave_capture_sequencer;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              m_ready = 1'b1;
  logic [CNT_W-1:0]  burst_len = '0;
  logic [15:0]       phase_step = '0;
`ifdef DECIM_EN
  logic [3:0]        decim = '0;
`endif
  logic              gen_en, filt_en, filt_clr, m_valid, m_last;
  logic              busy, done, aborted;
  logic [15:0]       gen_step;
  logic [DATA_W-1:0] filt_data, m_data;
  logic [15:0]       fcnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [16:0] exp_q[$];     // {last, data}
  int          exp_done[$];  // burst length of each expected done pulse
  logic [16:0] e;
  logic        prev_last_hs, prev_stall;
  logic [15:0] prev_data;
  logic        seen;
  int          k;

  wave_capture_sequencer dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .start_i      (start),
    .abort_i      (abort),
    .burst_len_i  (burst_len),
    .phase_step_i (phase_step),
`ifdef DECIM_EN
    .decim_i      (decim),
`endif
    .gen_en_o     (gen_en),
    .gen_step_o   (gen_step),
    .filt_en_o    (filt_en),
    .filt_clr_o   (filt_clr),
    .filt_data_i  (filt_data),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_last_o     (m_last),
    .busy_o       (busy),
    .done_o       (done),
    .aborted_o    (aborted)
  );

  always #5 clk = ~clk;

  // Filter stand-in.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)      fcnt <= '0;
    else if (filt_clr) fcnt <= '0;
    else if (filt_en)  fcnt <= fcnt + 16'd1;
  end
  assign filt_data = 16'hA000 + fcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: pops the scoreboard on each handshake and checks stream rules.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_last_hs = 1'b0;
      prev_stall   = 1'b0;
      prev_data    = '0;
    end else begin
      chk("filt_en_eq_gen_en", filt_en, gen_en);
      if (done) begin
        chk("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          if (exp_done.pop_front() != 0) chk("done_after_last_hs", prev_last_hs, 1);
          chk("all_samples_delivered", exp_q.size(), 0);
        end
      end
      if (prev_stall) begin
        chk("valid_held_in_stall", m_valid, 1);
        chk("data_held_in_stall", m_data, prev_data);
      end
      if (m_valid) chk("gen_en_tracks_ready", gen_en, m_ready);
      if (m_valid && m_ready) begin
        chk("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e[15:0]);
          chk("m_last", m_last, e[16]);
        end
      end
      prev_last_hs = m_valid && m_ready && m_last;
      prev_stall   = m_valid && !m_ready;
      prev_data    = m_data;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int n, input int first, input int stride);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), 16'(16'hA000 + first + i * stride)});
    end
  endtask

  // Returns one step after the edge that sampled start (CLEAR cycle).
  task automatic do_start(input int len, input logic [15:0] step);
    burst_len  = CNT_W'(len);
    phase_step = step;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && !m_valid; i++) tick();
  endtask

  // mode 1 drives m_ready with the repeating pattern 1,0,0,1 on valid cycles.
  task automatic wait_done(input int bound, input int mode, output logic found);
    logic [3:0] pat;
    int idx;
    pat   = 4'b1001;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      if (mode == 1 && m_valid) begin
        m_ready = pat[idx % 4];
        idx++;
      end
      tick();
    end
    m_ready = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {gen_en, filt_en, filt_clr, m_valid, m_last, busy, done, aborted,
             gen_step, m_data}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick(); tick();
    chk_all_zero("reset_values");
    reset_n = 1'b1;
    tick();
    chk_all_zero("idle_after_reset");

    // Basic burst of 4, full throughput
    push_burst(4, 6, 1);
    exp_done.push_back(4);
    do_start(4, 16'd1);
    chk("t2_filt_clr", filt_clr, 1);
    chk("t2_busy", busy, 1);
    chk("t2_gen_en_in_clear", gen_en, 0);
    chk("t2_gen_step", gen_step, 16'd1);
    tick();
    k = 2;
    chk("t2_filt_clr_one_cycle", filt_clr, 0);
    chk("t2_gen_en_warm", gen_en, 1);
    chk("t2_no_valid_warm", m_valid, 0);
    while (!m_valid && k < 20) begin
      tick();
      k++;
    end
    chk("t2_first_valid_latency", k, 8);
    wait_done(40, 0, seen);
    chk("t2_done_seen", seen, 1);
    tick();
    chk("t2_busy_after", busy, 0);
    chk("t2_done_one_cycle", done, 0);

    // Burst of 3 with back-pressure; a start while busy must be ignored
    push_burst(3, 6, 1);
    exp_done.push_back(3);
    do_start(3, 16'h1234);
    tick();
    burst_len  = CNT_W'(7);
    phase_step = 16'hFFFF;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    chk("t3_step_unchanged", gen_step, 16'h1234);
    wait_done(60, 1, seen);
    chk("t3_done_seen", seen, 1);
    tick();
    chk("t3_busy_after", busy, 0);

    // Abort in the second RUN cycle of a 10-sample burst
    push_burst(10, 6, 1);
    do_start(10, 16'd5);
    wait_valid(20);
    chk("t4_in_run", m_valid, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_aborted", aborted, 1);
    chk("t4_valid_off", m_valid, 0);
    chk("t4_gen_en_off", gen_en, 0);
    chk("t4_busy_off", busy, 0);
    chk("t4_no_done", done, 0);
    chk("t4_samples_taken", exp_q.size(), 8);
    exp_q.delete();
    tick();
    chk("t4_aborted_one_cycle", aborted, 0);

    // Zero-length burst, then start+abort together in IDLE
    exp_done.push_back(0);
    do_start(0, 16'd2);
    chk("t5_done", done, 1);
    chk("t5_no_valid", m_valid, 0);
    tick();
    chk("t5_done_one_cycle", done, 0);
    chk("t5_busy_after", busy, 0);
    chk("t5_no_valid_after", m_valid, 0);
    burst_len = CNT_W'(5);
    start     = 1'b1;
    abort     = 1'b1;
    tick();
    start     = 1'b0;
    abort     = 1'b0;
    chk("t5_start_abort_busy", busy, 0);
    chk("t5_start_abort_clr", filt_clr, 0);
    chk("t5_start_abort_no_pulse", aborted, 0);

    // Reset in the middle of RUN, then a normal burst
    push_burst(5, 6, 1);
    do_start(5, 16'd3);
    wait_valid(20);
    chk("t1_in_run", m_valid, 1);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk_all_zero("t1_reset_immediate");
    tick(); tick();
    chk_all_zero("t1_reset_held");
    reset_n = 1'b1;
    tick();
    chk_all_zero("t1_after_release");
    push_burst(2, 6, 1);
    exp_done.push_back(2);
    do_start(2, 16'd7);
    chk("t1_restart_clr", filt_clr, 1);
    chk("t1_restart_step", gen_step, 16'd7);
    wait_done(40, 0, seen);
    chk("t1_restart_done_seen", seen, 1);
    tick();

`ifdef DECIM_EN
    // Every third filter sample presented
    decim = 4'd2;
    push_burst(3, 8, 3);
    exp_done.push_back(3);
    do_start(3, 16'd1);
    wait_done(60, 0, seen);
    chk("t6_done_seen", seen, 1);
    tick();
    decim = 4'd0;
`endif

    tick(); tick();
    chk("final_sb_empty", exp_q.size(), 0);
    chk("final_done_q_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_wave_capture_sequencer

`default_nettype wire
